bcd_seq_convert: RTL and testbench

BCD_SEQ_CONVERT -- requirements
Module: bcd_seq_convert

---
 rtl/bcd_seq_if.sv | 14 +
 rtl/bcd_seq_convert.sv | 113 +++++++++++
 tb/tb_bcd_seq_convert.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/bcd_seq_if.sv
// Handshake and result bundle for the sequential binary-to-BCD converter.
interface bcd_seq_if;
   logic       start;
   logic [9:0] bin_in;
   logic       busy;
   logic       done;
   logic [3:0] hun;
   logic [3:0] ten;
   logic [3:0] one;
   logic       ovf;

   modport master (output start, bin_in, input busy, done, hun, ten, one, ovf);
   modport slave  (input start, bin_in, output busy, done, hun, ten, one, ovf);
endinterface

// File: rtl/bcd_seq_convert.sv
// Sequential 10-bit binary to 3-digit BCD converter (shift-add-3, one bit per clock).
// Optional macro BCD_CLAMP_EN: operands above 999 are clamped to 999 and flagged on ovf.
//
// state   | meaning
// S_IDLE  | waiting for start; latches operand on the accepting edge
// S_SHIFT | one shift-add-3 step per clock while cnt != 0; cnt == 0 publishes result
// S_DONE  | done pulse cycle; returns to S_IDLE
module bcd_seq_convert (
   input  logic      clk,
   input  logic      rst_n,
   bcd_seq_if.slave  bus
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   logic [1:0]  state;
   logic [9:0]  opnd;
   logic [11:0] acc;
   logic [11:0] acc_adj;
   logic [3:0]  cnt;
   logic [9:0]  latch_val;
   logic        busy_q, done_q;
   logic [3:0]  hun_q, ten_q, one_q;
   logic        accept, finish;

   assign accept = (state == S_IDLE) && bus.start;
   assign finish = (state == S_SHIFT) && (cnt == 4'd0);

   // Hundreds nibble is left uncorrected so 1000-1023 read back as hun=A.
   always_comb begin
      acc_adj = acc;
      if (acc[3:0] >= 4'd5) acc_adj[3:0] = acc[3:0] + 4'd3;
      if (acc[7:4] >= 4'd5) acc_adj[7:4] = acc[7:4] + 4'd3;
   end

`ifdef BCD_CLAMP_EN
   logic ovf_pend, ovf_q;

   assign latch_val = (bus.bin_in > 10'd999) ? 10'd999 : bus.bin_in;
   assign bus.ovf   = ovf_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_pend <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         ovf_pend <= (bus.bin_in > 10'd999);
      end else if (finish) begin
         ovf_q    <= ovf_pend;
      end
   end
`else
   assign latch_val = bus.bin_in;
   assign bus.ovf   = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         opnd   <= '0;
         acc    <= '0;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         hun_q  <= '0;
         ten_q  <= '0;
         one_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               done_q <= 1'b0;
               if (bus.start) begin
                  opnd   <= latch_val;
                  acc    <= '0;
                  cnt    <= 4'd10;
                  busy_q <= 1'b1;
                  state  <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               if (cnt != 4'd0) begin
                  acc  <= {acc_adj[10:0], opnd[9]};
                  opnd <= {opnd[8:0], 1'b0};
                  cnt  <= cnt - 4'd1;
               end else begin
                  hun_q  <= acc[11:8];
                  ten_q  <= acc[7:4];
                  one_q  <= acc[3:0];
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  state  <= S_DONE;
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.hun  = hun_q;
   assign bus.ten  = ten_q;
   assign bus.one  = one_q;
endmodule

// File: tb/tb_bcd_seq_convert.sv
// Randomized self-checking bench for bcd_seq_convert against a decimal-arithmetic model.
module tb_bcd_seq_convert;
   logic clk;
   logic rst_n;
   bcd_seq_if bus ();

   bcd_seq_convert dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int last_h = 0, last_t = 0, last_o = 0, last_v = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model(input int v, output int h, output int t, output int o, output int ov);
      int e;
      e  = v;
      ov = 0;
`ifdef BCD_CLAMP_EN
      if (e > 999) begin
         e  = 999;
         ov = 1;
      end
`endif
      h = e / 100;
      t = (e / 10) % 10;
      o = e % 10;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_busy"}, int'(bus.busy), 0);
      chk({tag, "_done"}, int'(bus.done), 0);
      chk({tag, "_hun"},  int'(bus.hun), 0);
      chk({tag, "_ten"},  int'(bus.ten), 0);
      chk({tag, "_one"},  int'(bus.one), 0);
      chk({tag, "_ovf"},  int'(bus.ovf), 0);
   endtask

   // pulse_at >= 0 re-asserts start so it is sampled at edge E(pulse_at+1).
   task automatic convert(input logic [9:0] v, input bit scramble, input int pulse_at);
      int lat, h, t, o, ov;
      model(int'(v), h, t, o, ov);
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = v;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 0;
      while (!bus.done && lat < 30) begin
         chk("busy_run", int'(bus.busy), 1);
         chk("hold", int'({bus.hun, bus.ten, bus.one, bus.ovf}),
             int'({4'(last_h), 4'(last_t), 4'(last_o), 1'(last_v)}));
         if (scramble) bus.bin_in = 10'($urandom);
         bus.start = (lat == pulse_at);
         @(negedge clk);
         lat++;
      end
      bus.start = 1'b0;
      chk("latency", lat, 11);
      chk("busy_done", int'(bus.busy), 0);
      chk("hun", int'(bus.hun), h);
      chk("ten", int'(bus.ten), t);
      chk("one", int'(bus.one), o);
      chk("ovf", int'(bus.ovf), ov);
      last_h = h; last_t = t; last_o = o; last_v = ov;
      @(negedge clk);
      chk("done_pulse", int'(bus.done), 0);
   endtask

   initial begin
      int n_done, i1, i2, h, t, o, ov;
      bus.start  = 1'b0;
      bus.bin_in = '0;
      rst_n      = 1'b0;
      #1;
      chk_zero("reset");
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      convert(10'd45, 1'b0, -1);

      // back-to-back with start held high
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 10'd5;
      @(posedge clk);
      @(negedge clk);
      bus.bin_in = 10'd125;
      n_done = 0; i1 = 0; i2 = 0;
      for (int c = 1; c <= 60; c++) begin
         if (bus.done) begin
            n_done++;
            if (n_done == 1) begin
               i1 = c;
               chk("b2b1", int'({bus.hun, bus.ten, bus.one}), 12'h005);
            end else if (n_done == 2) begin
               i2 = c;
               chk("b2b2", int'({bus.hun, bus.ten, bus.one}), 12'h125);
               bus.start = 1'b0;
            end
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      chk("b2b_count", n_done, 2);
      chk("b2b_gap", i2 - i1, 13);
      last_h = 1; last_t = 2; last_o = 5; last_v = 0;

      // extra start inside a conversion is ignored
      convert(10'd999, 1'b0, 2);
      n_done = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      chk("no_requeue", n_done, 0);
      chk("idle_busy", int'(bus.busy), 0);

      // reset mid-conversion
      @(negedge clk);
      bus.start  = 1'b1;
      bus.bin_in = 10'd512;
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_zero("abort");
      last_h = 0; last_t = 0; last_o = 0; last_v = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_done = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.done) n_done++;
      end
      chk("abort_no_done", n_done, 0);
      convert(10'd512, 1'b0, -1);

      convert(10'd1023, 1'b0, -1);
      convert(10'd7, 1'b0, -1);
      convert(10'd0, 1'b0, -1);
      convert(10'd300, 1'b1, -1);

      for (int i = 0; i < 40; i++)
         convert(10'($urandom_range(0, 1023)), 1'($urandom), -1);

      model(1000, h, t, o, ov);
      convert(10'd1000, 1'b1, -1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
